// File: rtl/dmem_write_buffer.sv
// ---------------------------------------------------------------------------
// dmem_write_buffer
//
// Data-memory front end between a single-cycle CPU data port and a memory
// with a one-outstanding req/ack handshake. Stores retire immediately into a
// small FIFO write buffer and drain to memory in the background. Loads are
// serialised onto the same memory port. The block raises `stall` while a load
// (or a store hitting a full buffer) has to wait.
//
// Optional feature macro: STORE_FORWARD_EN
//   defined   : loads are compared against every buffered store. A hit is
//               answered combinationally from the youngest matching entry.
//               A miss goes to memory ahead of the buffered stores.
//   undefined : there are no comparators. A load waits until the buffer has
//               fully drained.
//
// Ports
//   clk, rst          : clock; synchronous active-high reset
//   cpu_addr          : CPU byte address (bits [1:0] ignored)
//   cpu_wdata         : CPU store data
//   cpu_read/write    : CPU load/store request levels (write wins if both)
//   cpu_rdata         : load data returned to the CPU
//   stall             : combinational hold request to the CPU
//   mem_req/we        : registered memory request / write-enable
//   mem_addr/wdata    : registered word-aligned address / write data
//   mem_rdata/ack     : memory read data / request completion
//   wb_count          : number of occupied write-buffer entries
// ---------------------------------------------------------------------------
module dmem_write_buffer #(
    parameter int WB_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               cpu_addr,
    input  logic [31:0]               cpu_wdata,
    input  logic                      cpu_read,
    input  logic                      cpu_write,
    output logic [31:0]               cpu_rdata,
    output logic                      stall,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata,
    input  logic                      mem_ack,
    output logic [$clog2(WB_DEPTH):0] wb_count
);

    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RD_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [29:0]   fifo_addr_q [WB_DEPTH];
    logic [29:0]   fifo_addr_d [WB_DEPTH];
    logic [31:0]   fifo_data_q [WB_DEPTH];
    logic [31:0]   fifo_data_d [WB_DEPTH];

    logic          is_load;
    logic          full;
    logic          push;
    logic          pop;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic          load_fwd;
    logic          load_eligible;
    logic          start_rd;
    logic          start_wr;

    logic [1:0]    unused_addr_bits;
    assign unused_addr_bits = cpu_addr[1:0];

    // A simultaneous read+write is a store. A store is accepted whenever the
    // buffer has room. An entry leaves only when memory acknowledges its write.
    assign is_load = cpu_read & ~cpu_write;
    assign full    = (count_q == CW'(WB_DEPTH));
    assign push    = cpu_write & ~full;
    assign pop     = (state_q == WR) & mem_ack;

`ifdef STORE_FORWARD_EN
    // Scan the valid entries from oldest to youngest so that the last match
    // seen (the youngest store to that word) wins. The head entry currently
    // being written to memory is still valid here, so it is included.
    logic [PW-1:0] scan_idx;
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        scan_idx = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            scan_idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (fifo_addr_q[scan_idx] == cpu_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data_q[scan_idx];
            end
        end
    end

    // A missing load goes to memory right away, ahead of buffered stores.
    assign load_eligible = is_load & ~fwd_hit;
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;

    // Without forwarding, a load is safe only once every older store has
    // reached memory, i.e. once the buffer will be empty after this edge.
    assign load_eligible = is_load & (count_d == '0);
`endif

    // Forwarding applies only while the port is idle or draining stores.
    // During RD/RD_DONE the load is already committed to memory.
    assign load_fwd = is_load & fwd_hit & ((state_q == IDLE) || (state_q == WR));

    // Stall covers a store into a full buffer and any load that is neither
    // forwarded nor completing in RD_DONE. Reset forces it low.
    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            stall = (cpu_write & full)
                  | (is_load & ~load_fwd & (state_q != RD_DONE));
        end
    end

    assign cpu_rdata = load_fwd ? fwd_data : rdata_q;

    // Buffer bookkeeping for this cycle. The *_d arrays include this cycle's
    // push. So fifo_*_d[rd_ptr_d] is the head the FSM should issue next, even
    // if that head is the store arriving right now.
    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        if (push) begin
            fifo_addr_d[wr_ptr_q] = cpu_addr[31:2];
            fifo_data_d[wr_ptr_q] = cpu_wdata;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Port sequencer. Each state decides whether the next edge starts a read,
    // starts a write of the next head, or goes quiet. The mem_* fields are
    // loaded only on the edge that enters a request state. They then stay
    // fixed until the ack arrives.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        start_rd    = 1'b0;
        start_wr    = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_eligible) begin
                    start_rd = 1'b1;
                end else if (count_d != '0) begin
                    start_wr = 1'b1;
                end
            end
            WR: begin
                if (mem_ack) begin
                    if (load_eligible) begin
                        start_rd = 1'b1;
                    end else if (count_d != '0) begin
                        start_wr = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end
            end
            RD: begin
                if (mem_ack) begin
                    state_d   = RD_DONE;
                    mem_req_d = 1'b0;
                    rdata_d   = mem_rdata;
                end
            end
            RD_DONE: begin
                if (count_d != '0) begin
                    start_wr = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        if (start_rd) begin
            state_d    = RD;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = {cpu_addr[31:2], 2'b00};
        end else if (start_wr) begin
            state_d     = WR;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {fifo_addr_d[rd_ptr_d], 2'b00};
            mem_wdata_d = fifo_data_d[rd_ptr_d];
        end
    end

    // Control and port registers. Reset abandons any in-flight transaction
    // and discards buffered stores by clearing the pointers and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // Buffer storage needs no reset. Entries are only read while the count
    // marks them valid.
    always_ff @(posedge clk) begin
        fifo_addr_q <= fifo_addr_d;
        fifo_data_q <= fifo_data_d;
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_count  = count_q;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// ---------------------------------------------------------------------------
// tb_dmem_write_buffer
//
// Directed bench for dmem_write_buffer (WB_DEPTH = 4). Inputs are driven 1 ns
// after each rising edge. Outputs are sampled 1 ns after that, well clear of
// the next edge. Sections guarded by STORE_FORWARD_EN follow the matching
// build of the design.
// ---------------------------------------------------------------------------
module tb_dmem_write_buffer;

    logic        clk;
    logic        rst;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [2:0]  wb_count;

    int checks   = 0;
    int failures = 0;

    dmem_write_buffer #(.WB_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .wb_count  (wb_count)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the CPU and memory-side inputs, then let combinational logic settle
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic ack, input logic [31:0] rdata);
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        mem_ack   = ack;
        mem_rdata = rdata;
        #1;
    endtask

    // One comparison against a hand-computed expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);

        // Reset: stall is forced low even with a load pending
        tick();
        checkOutput("rst_stall", 32'(stall), 32'd0);
        tick();
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        checkOutput("rst_wb_count", 32'(wb_count), 32'd0);
        checkOutput("rst_cpu_rdata", cpu_rdata, 32'h0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);

        // Single store with ack tied high. Byte offset bits are dropped.
        tick();
        applyStimulus(1'b0, 1'b1, 32'h13, 32'hDEADBEEF, 1'b1, 32'h0);
        checkOutput("st1_stall", 32'(stall), 32'd0);
        checkOutput("st1_req_before", 32'(mem_req), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        checkOutput("st1_req", 32'(mem_req), 32'd1);
        checkOutput("st1_we", 32'(mem_we), 32'd1);
        checkOutput("st1_addr", mem_addr, 32'h10);
        checkOutput("st1_wdata", mem_wdata, 32'hDEADBEEF);
        checkOutput("st1_count_pre", 32'(wb_count), 32'd1);
        tick();
        checkOutput("st1_count_post", 32'(wb_count), 32'd0);
        checkOutput("st1_req_idle", 32'(mem_req), 32'd0);

        // Five stores with ack low: the fifth sees a full buffer
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h50 + 32'(4 * i), 32'(i + 1), 1'b0, 32'h0);
            checkOutput("fill_stall", 32'(stall), 32'd0);
            tick();
        end
        applyStimulus(1'b0, 1'b1, 32'h60, 32'd5, 1'b0, 32'h0);
        checkOutput("full_count", 32'(wb_count), 32'd4);
        checkOutput("full_stall", 32'(stall), 32'd1);
        tick();
        checkOutput("full_stall_hold", 32'(stall), 32'd1);
        checkOutput("full_head_addr", mem_addr, 32'h50);
        applyStimulus(1'b0, 1'b1, 32'h60, 32'd5, 1'b1, 32'h0);
        checkOutput("full_stall_ack", 32'(stall), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h60, 32'd5, 1'b0, 32'h0);
        checkOutput("freed_stall", 32'(stall), 32'd0);
        checkOutput("freed_count", 32'(wb_count), 32'd3);
        checkOutput("b2b_req", 32'(mem_req), 32'd1);
        checkOutput("b2b_addr", mem_addr, 32'h54);
        checkOutput("b2b_wdata", mem_wdata, 32'd2);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        checkOutput("refill_count", 32'(wb_count), 32'd4);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("drain_count", 32'(wb_count), 32'd0);
        checkOutput("drain_req", 32'(mem_req), 32'd0);

        // Load from an empty buffer, ack on the third RD cycle
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
        checkOutput("ld_stall_c0", 32'(stall), 32'd1);
        tick();
        checkOutput("ld_stall_c1", 32'(stall), 32'd1);
        checkOutput("ld_req", 32'(mem_req), 32'd1);
        checkOutput("ld_we", 32'(mem_we), 32'd0);
        checkOutput("ld_addr", mem_addr, 32'h20);
        tick();
        checkOutput("ld_stall_c2", 32'(stall), 32'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h12345678);
        checkOutput("ld_stall_c3", 32'(stall), 32'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
        checkOutput("ld_done_stall", 32'(stall), 32'd0);
        checkOutput("ld_done_rdata", cpu_rdata, 32'h12345678);
        checkOutput("ld_done_req", 32'(mem_req), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

        // Two stores to the same word, then a load of that word
        applyStimulus(1'b0, 1'b1, 32'h40, 32'd1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h40, 32'd2, 1'b0, 32'h0);
        tick();
`ifdef STORE_FORWARD_EN
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
        checkOutput("fwd_stall", 32'(stall), 32'd0);
        checkOutput("fwd_rdata", cpu_rdata, 32'd2);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("fwd_no_read", 32'(mem_we), 32'd1);
        checkOutput("fwd_wr_addr", mem_addr, 32'h40);
        checkOutput("fwd_count", 32'(wb_count), 32'd2);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        tick();
        tick();
        checkOutput("fwd_drain_count", 32'(wb_count), 32'd0);
`else
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'h0);
        checkOutput("nofwd_stall_a", 32'(stall), 32'd1);
        checkOutput("nofwd_wdata_a", mem_wdata, 32'd1);
        tick();
        checkOutput("nofwd_stall_b", 32'(stall), 32'd1);
        checkOutput("nofwd_we_b", 32'(mem_we), 32'd1);
        checkOutput("nofwd_wdata_b", mem_wdata, 32'd2);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'hCAFE0040);
        checkOutput("nofwd_rd_we", 32'(mem_we), 32'd0);
        checkOutput("nofwd_rd_req", 32'(mem_req), 32'd1);
        checkOutput("nofwd_rd_addr", mem_addr, 32'h40);
        checkOutput("nofwd_rd_count", 32'(wb_count), 32'd0);
        checkOutput("nofwd_rd_stall", 32'(stall), 32'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
        checkOutput("nofwd_done_stall", 32'(stall), 32'd0);
        checkOutput("nofwd_done_rdata", cpu_rdata, 32'hCAFE0040);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
`endif

`ifdef STORE_FORWARD_EN
        // A missing load overtakes the remaining buffered stores
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'h100 + 32'(4 * i), 1'b0, 32'h0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h0);
        checkOutput("prio_stall_wr", 32'(stall), 32'd1);
        checkOutput("prio_wr_addr", mem_addr, 32'h100);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h0000ABCD);
        checkOutput("prio_rd_we", 32'(mem_we), 32'd0);
        checkOutput("prio_rd_addr", mem_addr, 32'h200);
        checkOutput("prio_rd_count", 32'(wb_count), 32'd2);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0);
        checkOutput("prio_done_rdata", cpu_rdata, 32'h0000ABCD);
        checkOutput("prio_done_stall", 32'(stall), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        checkOutput("prio_next_addr", mem_addr, 32'h104);
        checkOutput("prio_next_we", 32'(mem_we), 32'd1);
        tick();
        tick();
        checkOutput("prio_drain_count", 32'(wb_count), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
`endif

        // Reset with buffered stores: they are discarded
        applyStimulus(1'b0, 1'b1, 32'h90, 32'h9, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h94, 32'hA, 1'b0, 32'h0);
        tick();
        checkOutput("pre_rst_count", 32'(wb_count), 32'd2);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rstwb_count", 32'(wb_count), 32'd0);
        checkOutput("rstwb_req", 32'(mem_req), 32'd0);
        tick();
        checkOutput("rstwb_req_hold", 32'(mem_req), 32'd0);

        // Reset during RD: the read is abandoned
        applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
        tick();
        checkOutput("rstrd_req_pre", 32'(mem_req), 32'd1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("rstrd_stall_in_rst", 32'(stall), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rstrd_req", 32'(mem_req), 32'd0);
        checkOutput("rstrd_count", 32'(wb_count), 32'd0);
        checkOutput("rstrd_stall", 32'(stall), 32'd0);
        checkOutput("rstrd_rdata", cpu_rdata, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_write_buffer.md
# dmem_write_buffer

Data-memory front end sitting directly downstream of the single-cycle CPU's data port (`data_addr`, `data_out`, `data_in`, `mem_read`, `mem_write`). It holds stores in a small FIFO write buffer so they retire without stalling, and serialises loads and buffered stores onto a one-outstanding req/ack memory port. It asserts `stall` so the core can freeze its PC and suppress register writeback while a load or a full-buffer store waits.

## Interface
- `WB_DEPTH`, 4: write-buffer entries; power of two, ≥2
- `clk` in 1: clock; all state updates on rising edge
- `rst` in 1: reset; one clock; reset is synchronous and active-high
- `cpu_addr` in 32: byte address; bits [1:0] ignored, word granularity
- `cpu_wdata` in 32: store data
- `cpu_read` in 1: load request, level, held stable while `stall`=1
- `cpu_write` in 1: store request, level, held stable while `stall`=1
- `cpu_rdata` out 32: load data, valid in a cycle with `cpu_read`=1 and `stall`=0
- `stall` out 1: combinational; core holds its current instruction while high
- `mem_req` out 1: memory request, registered
- `mem_we` out 1: 1 = write, 0 = read, registered
- `mem_addr` out 32: word-aligned address ([1:0]=0), registered
- `mem_wdata` out 32: write data, registered
- `mem_rdata` in 32: read data, sampled with `mem_ack`
- `mem_ack` in 1: completes the current request at the sampling edge
- `wb_count` out log2(WB_DEPTH)+1: occupied entries

## Operation
- FIFO entries {addr[31:2], data}; head = oldest. Push: `cpu_write`=1 and not full. Pop: ack of a WR. Push and pop in the same cycle leave count unchanged.
- `cpu_read` and `cpu_write` both high is treated as a store only.
- Store stall: `stall` = `cpu_write` & (count==WB_DEPTH). A pop frees a slot; the stalled store pushes on the following edge.
- FSM states: IDLE, WR, RD, RD_DONE.
  - IDLE: `mem_req`=0. Eligible load pending → RD (latch `cpu_addr`). Else buffer non-empty → WR with head. Else stay.
  - WR: `mem_req`=1, `mem_we`=1, head addr/data. On ack: pop; eligible load → RD; else remaining entries → WR with next head; else IDLE.
  - RD: `mem_req`=1, `mem_we`=0. On ack: latch `mem_rdata` into rdata register → RD_DONE.
  - RD_DONE: `stall`=0, `cpu_rdata`=rdata register; core retires the load this edge. Next: WR if buffer non-empty, else IDLE.
- Load stall: `stall`=1 for `cpu_read` in IDLE/WR/RD unless forwarded.
- `mem_*` outputs change only on the edge entering a state. They hold stable until ack. `mem_ack` in IDLE/RD_DONE is ignored.

## Timing
- Reset values: state IDLE, count 0, pointers 0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, rdata register 0, `cpu_rdata`=0. `stall` forced 0 while `rst`=1.
- Store, buffer not full: zero stall cycles. Issued to memory no earlier than the next cycle.
- Load, no forward, port idle: stall in cycle t (IDLE) and in every RD cycle. With ack in the first RD cycle, the load completes in t+2 (2 stall cycles).
- A load arriving during WR waits for that WR ack, then goes straight to RD.
- Back-to-back: a new request may begin the cycle after an ack, with `mem_req` staying high and new fields.
- Reset mid-operation: in-flight transaction abandoned. `mem_req` low after the reset edge. Buffered stores discarded.

## Configuration
- `STORE_FORWARD_EN` defined:
  - A load compares addr[31:2] against all valid entries, including a head currently in WR.
  - On a match in IDLE/WR, `cpu_rdata` = data of the youngest match, combinationally. `stall`=0, no memory access, FSM unaffected.
  - A non-matching load is eligible at once and is prioritised over buffered stores.
- Undefined:
  - No comparators.
  - A load is eligible only when the buffer is empty. Until then the FSM drains the buffer and `stall` stays high.

## Test plan
- Reset, `mem_ack` tied 1; store 0x10←0xDEADBEEF → `stall` 0; next cycle `mem_req`=1, `mem_we`=1, `mem_addr`=0x10, `mem_wdata`=0xDEADBEEF; `wb_count` 1→0 on that edge.
- WB_DEPTH=4, `mem_ack`=0, five consecutive stores → first four `stall`=0, `wb_count`=4. Fifth `stall`=1 until one ack; it pushes the edge after, count stays 4.
- Empty buffer, load 0x20, memory acks on the 3rd RD cycle with 0x12345678 → `stall`=1 for 4 cycles, then `cpu_rdata`=0x12345678 with `stall`=0 for one cycle.
- Forward on: store 0x40←1, store 0x40←2 (`mem_ack`=0), load 0x40 → `stall`=0 in the same cycle, `cpu_rdata`=2, no read request. Forward off: `stall` until both stores ack, then RD to 0x40.
- Forward on: three stores to 0x100/0x104/0x108, WR to 0x100 in flight, load 0x200 → RD to 0x200 issued the cycle after the 0x100 ack, before 0x104; `wb_count`=2 during RD.
- `rst` pulsed during RD with `mem_req`=1 → next cycle `mem_req`=0, `wb_count`=0, `stall`=0, `cpu_rdata`=0.
